// File: rtl/mem_stage_lsu_pkg.sv
// Shared widths, access-size encodings and LSU FSM states for the MEM stage.
package mem_stage_lsu_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned STRB_W     = DATA_W / 8;

    // funct3[1:0] gives the access size; funct3[2] marks an unsigned load
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } accSize_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsuState_e;

    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLo);
        logic mis;
        case (funct3[1:0])
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addrLo[0];
            default: mis = (addrLo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Request/grant/response data-memory bus between the LSU (master) and memory (slave).
interface mem_stage_lsu_if;
    import mem_stage_lsu_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane steering: store strobes/replicated data and load lane extraction with extension.
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addrLo,
    input  logic [DATA_W-1:0] storeData,
    input  logic [DATA_W-1:0] rdata,
    output logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] loadData
);

    logic [DATA_W-1:0] laneData;
    logic              signByte;
    logic              signHalf;

    assign laneData = rdata >> {addrLo, 3'b000};
    assign signByte = laneData[7]  & ~funct3[2];
    assign signHalf = laneData[15] & ~funct3[2];

    always_comb begin
        wstrb    = '1;
        wdata    = storeData;
        loadData = laneData;
        case (funct3[1:0])
            SZ_BYTE: begin
                wstrb    = STRB_W'(1) << addrLo;
                wdata    = {(DATA_W/8){storeData[7:0]}};
                loadData = {{(DATA_W-8){signByte}}, laneData[7:0]};
            end
            SZ_HALF: begin
                wstrb    = STRB_W'(3) << addrLo;
                wdata    = {(DATA_W/16){storeData[15:0]}};
                loadData = {{(DATA_W-16){signHalf}}, laneData[15:0]};
            end
            default: begin
                wstrb    = '1;
                wdata    = storeData;
                loadData = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: issues loads/stores on the memory bus, stalls while outstanding,
// and forwards ALU result and writeback control to MEM/WB.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [ADDR_W-1:0]     pc_ex,
    input  logic                  memRead_i,
    input  logic                  memWrite_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_W-1:0]     aluResult_i,
    input  logic [DATA_W-1:0]     storeData_i,
    input  logic                  registerWriteEnable_i,
    input  logic                  regSelect_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    mem_stage_lsu_if.master       mem,
    output logic                  stall_o,
    output logic                  misalign_o,
    output logic [ADDR_W-1:0]     pc_mem,
    output logic                  registerWriteEnable_o,
    output logic                  regSelect_o,
    output logic [DATA_W-1:0]     aluSrc_o,
    output logic [DATA_W-1:0]     rdData_o,
    output logic [REG_ADDR_W-1:0] rd_o
);

    lsuState_e         state;
    logic [DATA_W-1:0] loadData_q;
    logic              doneFlag_q;
    logic [ADDR_W-1:0] donePc_q;

    logic              memOp;
    logic              isLoad;
    logic              misaligned;
    logic              blocked;
    logic              issue;
    logic [DATA_W-1:0] alignedLoad;
    logic [DATA_W-1:0] laneWdata;
    logic [STRB_W-1:0] laneWstrb;

    assign memOp      = valid_i & (memRead_i | memWrite_i);
    assign isLoad     = memRead_i & ~memWrite_i;
    assign misaligned = memOp & isMisaligned(funct3_i, aluResult_i[1:0]);
    // A completed instruction still sitting in EX/MEM must not be re-issued
    assign blocked    = doneFlag_q & valid_i & (pc_ex == donePc_q);
    assign issue      = (state == IDLE) & memOp & ~misaligned & ~blocked;

    mem_stage_lsu_align u_align (
        .funct3    (funct3_i),
        .addrLo    (aluResult_i[1:0]),
        .storeData (storeData_i),
        .rdata     (mem.mem_rdata),
        .wstrb     (laneWstrb),
        .wdata     (laneWdata),
        .loadData  (alignedLoad)
    );

    // Bus transaction sequencing and load-data capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            loadData_q <= '0;
            doneFlag_q <= 1'b0;
            donePc_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!blocked) doneFlag_q <= 1'b0;
                    if (issue) state <= mem.mem_gnt ? WAIT : REQ;
                end
                REQ: begin
                    if (mem.mem_gnt) state <= WAIT;
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        if (isLoad) loadData_q <= alignedLoad;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    doneFlag_q <= 1'b1;
                    donePc_q   <= pc_ex;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and stall decode; everything is held quiet while reset is asserted
    always_comb begin
        mem.mem_req = 1'b0;
        stall_o     = 1'b0;
        misalign_o  = 1'b0;
        if (rst) begin
            unique case (state)
                IDLE: begin
                    mem.mem_req = issue;
                    stall_o     = issue;
                    misalign_o  = misaligned;
                end
                REQ: begin
                    mem.mem_req = 1'b1;
                    stall_o     = 1'b1;
                end
                WAIT:    stall_o = 1'b1;
                default: stall_o = 1'b0;
            endcase
        end
    end

    assign mem.mem_we    = memWrite_i;
    assign mem.mem_addr  = {aluResult_i[ADDR_W-1:2], 2'b00};
    assign mem.mem_wdata = laneWdata;
    assign mem.mem_wstrb = laneWstrb;

    assign pc_mem                = pc_ex;
    assign registerWriteEnable_o = registerWriteEnable_i & valid_i & ~misalign_o;
    assign regSelect_o           = regSelect_i;
    assign aluSrc_o              = aluResult_i;
    assign rdData_o              = loadData_q;
    assign rd_o                  = rd_i;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed sequences, a vector table and a randomized model check.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [31:0] pc_ex;
    logic        memRead_i;
    logic        memWrite_i;
    logic [2:0]  funct3_i;
    logic [31:0] aluResult_i;
    logic [31:0] storeData_i;
    logic        registerWriteEnable_i;
    logic        regSelect_i;
    logic [4:0]  rd_i;
    logic        stall_o;
    logic        misalign_o;
    logic [31:0] pc_mem;
    logic        registerWriteEnable_o;
    logic        regSelect_o;
    logic [31:0] aluSrc_o;
    logic [31:0] rdData_o;
    logic [4:0]  rd_o;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] pcNext   = 32'h1000;
    logic [31:0] expRd    = 32'h0;
    bit          rdKnown  = 1'b1;

    mem_stage_lsu_if bus ();

    mem_stage_lsu dut (
        .clk                   (clk),
        .rst                   (rst),
        .valid_i               (valid_i),
        .pc_ex                 (pc_ex),
        .memRead_i             (memRead_i),
        .memWrite_i            (memWrite_i),
        .funct3_i              (funct3_i),
        .aluResult_i           (aluResult_i),
        .storeData_i           (storeData_i),
        .registerWriteEnable_i (registerWriteEnable_i),
        .regSelect_i           (regSelect_i),
        .rd_i                  (rd_i),
        .mem                   (bus),
        .stall_o               (stall_o),
        .misalign_o            (misalign_o),
        .pc_mem                (pc_mem),
        .registerWriteEnable_o (registerWriteEnable_o),
        .regSelect_o           (regSelect_o),
        .aluSrc_o              (aluSrc_o),
        .rdData_o              (rdData_o),
        .rd_o                  (rd_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdat;
        int          gd;
        int          rvd;
        logic        mis;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic [31:0] ld;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setInstr(input logic v, input logic mr, input logic mw, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sd, input logic we,
                            input logic [4:0] rdx);
        valid_i               = v;
        memRead_i             = mr;
        memWrite_i            = mw;
        funct3_i              = f3;
        aluResult_i           = addr;
        storeData_i           = sd;
        registerWriteEnable_i = we;
        regSelect_i           = 1'($urandom_range(0, 1));
        rd_i                  = rdx;
        pc_ex                 = pcNext;
        pcNext                = pcNext + 32'd4;
    endtask

    // Reference: size/sign rules expressed with plain arithmetic
    function automatic void model(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd,
                                  input logic [31:0] rdat, output logic mis, output logic [3:0] strb,
                                  output logic [31:0] wd, output logic [31:0] ld);
        int unsigned      size;
        int unsigned      off;
        longint unsigned  raw;
        longint unsigned  lim;
        size = 32'd1 << f3[1:0];
        off  = addr % 4;
        mis  = (addr % size) != 0;
        strb = 4'(((32'd1 << size) - 32'd1) << off);
        if (size == 1)      wd = 32'(sd[7:0])  * 32'h01010101;
        else if (size == 2) wd = 32'(sd[15:0]) * 32'h00010001;
        else                wd = sd;
        if (size == 4) ld = rdat;
        else begin
            lim = 64'd1 << (8 * size);
            raw = (64'(rdat) >> (8 * off)) % lim;
            if (!f3[2] && raw >= lim / 2) raw = raw + (64'h1_0000_0000 - lim);
            ld = 32'(raw);
        end
    endfunction

    // Drives grant/response with the given delays and checks every cycle of the transaction
    task automatic runMem(input bit isStore, input logic [3:0] strb, input logic [31:0] wd,
                          input logic [31:0] ld, input int gd, input int rvd,
                          input logic [31:0] rdat, input string nm);
        for (int c = 0; c <= gd; c++) begin
            bus.mem_gnt    = (c == gd);
            bus.mem_rvalid = 1'b0;
            @(negedge clk);
            chk({nm, " req"},   32'(bus.mem_req), 32'd1);
            chk({nm, " stall"}, 32'(stall_o), 32'd1);
            chk({nm, " we"},    32'(bus.mem_we), 32'(isStore));
            chk({nm, " addr"},  bus.mem_addr, aluResult_i & ~32'h3);
            if (isStore) begin
                chk({nm, " wstrb"}, 32'(bus.mem_wstrb), 32'(strb));
                chk({nm, " wdata"}, bus.mem_wdata, wd);
            end
            nextCycle();
        end
        bus.mem_gnt = 1'b0;
        for (int c = 0; c <= rvd; c++) begin
            bus.mem_rvalid = (c == rvd);
            bus.mem_rdata  = (c == rvd) ? rdat : $urandom;
            @(negedge clk);
            chk({nm, " wait req"},   32'(bus.mem_req), 32'd0);
            chk({nm, " wait stall"}, 32'(stall_o), 32'd1);
            nextCycle();
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
        @(negedge clk);
        chk({nm, " done stall"}, 32'(stall_o), 32'd0);
        chk({nm, " done req"},   32'(bus.mem_req), 32'd0);
        chk({nm, " done regwe"}, 32'(registerWriteEnable_o), 32'(registerWriteEnable_i));
        chk({nm, " done alu"},   aluSrc_o, aluResult_i);
        if (!isStore) chk({nm, " rdData"}, rdData_o, ld);
        nextCycle();
        if (isStore) rdKnown = 1'b0;
        else begin
            expRd   = ld;
            rdKnown = 1'b1;
        end
    endtask

    task automatic misCycle(input string nm);
        @(negedge clk);
        chk({nm, " misalign"}, 32'(misalign_o), 32'd1);
        chk({nm, " req"},      32'(bus.mem_req), 32'd0);
        chk({nm, " stall"},    32'(stall_o), 32'd0);
        chk({nm, " regwe"},    32'(registerWriteEnable_o), 32'd0);
        nextCycle();
    endtask

    task automatic passCycle(input string nm);
        @(negedge clk);
        chk({nm, " req"},      32'(bus.mem_req), 32'd0);
        chk({nm, " stall"},    32'(stall_o), 32'd0);
        chk({nm, " misalign"}, 32'(misalign_o), 32'd0);
        chk({nm, " alu"},      aluSrc_o, aluResult_i);
        chk({nm, " pc"},       pc_mem, pc_ex);
        chk({nm, " rd"},       32'(rd_o), 32'(rd_i));
        chk({nm, " regsel"},   32'(regSelect_o), 32'(regSelect_i));
        chk({nm, " regwe"},    32'(registerWriteEnable_o), 32'(registerWriteEnable_i & valid_i));
        if (rdKnown) chk({nm, " rdData hold"}, rdData_o, expRd);
        nextCycle();
    endtask

    initial begin
        logic        mis;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic [31:0] ld;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdat;
        logic [2:0]  f3;
        logic        mr;
        logic        mw;
        int          kind;

        rst = 1'b0;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 32'h0;
        setInstr(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset req",      32'(bus.mem_req), 32'd0);
        chk("reset stall",    32'(stall_o), 32'd0);
        chk("reset misalign", 32'(misalign_o), 32'd0);
        chk("reset rdData",   rdData_o, 32'd0);
        rst = 1'b1;
        nextCycle();

        // ALU op passes straight through
        setInstr(1'b1, 1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 1'b1, 5'd5);
        passCycle("alu");

        // LW minimum latency, then the held instruction must not re-issue
        setInstr(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 5'd6);
        runMem(1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, "lw100");
        @(negedge clk);
        chk("noreissue req",   32'(bus.mem_req), 32'd0);
        chk("noreissue stall", 32'(stall_o), 32'd0);
        nextCycle();

        setInstr(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 5'd7);
        runMem(1'b0, 4'h0, 32'h0, 32'hFFFFFF80, 0, 1, 32'h80123456, "lb103");
        setInstr(1'b1, 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1'b1, 5'd7);
        runMem(1'b0, 4'h0, 32'h0, 32'h00000080, 1, 0, 32'h80123456, "lbu103");

        setInstr(1'b1, 1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 1'b0, 5'd0);
        runMem(1'b1, 4'b1100, 32'hABCDABCD, 32'h0, 3, 0, 32'h0, "sh102");

        setInstr(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 5'd8);
        misCycle("lw101");

        // Load whose result becomes known, then reset while in WAIT
        setInstr(1'b1, 1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 1'b1, 5'd9);
        runMem(1'b0, 4'h0, 32'h0, 32'h00C0FFEE, 0, 0, 32'h00C0FFEE, "lw104");
        setInstr(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b1, 5'd9);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        chk("rstseq req", 32'(bus.mem_req), 32'd1);
        nextCycle();
        bus.mem_gnt = 1'b0;
        @(negedge clk);
        chk("rstseq wait stall", 32'(stall_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("rstseq req",    32'(bus.mem_req), 32'd0);
        chk("rstseq stall",  32'(stall_o), 32'd0);
        chk("rstseq rdData", rdData_o, 32'd0);
        valid_i = 1'b0;
        nextCycle();
        rst = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h55555555;
        @(negedge clk);
        chk("late rvalid stall", 32'(stall_o), 32'd0);
        nextCycle();
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        chk("late rvalid rdData", rdData_o, 32'd0);
        nextCycle();
        expRd   = 32'h0;
        rdKnown = 1'b1;

        // Vector table: lane steering, extension and misalignment boundaries
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h201, 32'h0,        32'h0000FF00, 0, 0, 1'b0, 4'h0,    32'h0,        32'hFFFFFFFF});
        vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h202, 32'h0,        32'h00AB0000, 1, 0, 1'b0, 4'h0,    32'h0,        32'h000000AB});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h202, 32'h0,        32'h80010000, 0, 2, 1'b0, 4'h0,    32'h0,        32'hFFFF8001});
        vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h200, 32'h0,        32'h1234F00D, 0, 0, 1'b0, 4'h0,    32'h0,        32'h0000F00D});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h200, 32'h0,        32'h00007FFF, 2, 1, 1'b0, 4'h0,    32'h0,        32'h00007FFF});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h200, 32'h0,        32'h12345678, 0, 0, 1'b0, 4'h0,    32'h0,        32'h12345678});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0,        0, 0, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h200, 32'hFFFFFF3C, 32'h0,        1, 1, 1'b0, 4'b0001, 32'h3C3C3C3C, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h200, 32'h1234BEEF, 32'h0,        0, 0, 1'b0, 4'b0011, 32'hBEEFBEEF, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0,        0, 0, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 3'b010, 32'h208, 32'h11223344, 32'h0,        0, 0, 1'b0, 4'b1111, 32'h11223344, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h203, 32'h0,        32'h0,        0, 0, 1'b1, 4'h0,    32'h0,        32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h206, 32'h0,        32'h0,        0, 0, 1'b1, 4'h0,    32'h0,        32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h201, 32'h0,        32'h0,        0, 0, 1'b1, 4'h0,    32'h0,        32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h205, 32'h0,        32'h0,        0, 0, 1'b1, 4'h0,    32'h0,        32'h0});
        foreach (vecs[i]) begin
            setInstr(1'b1, vecs[i].mr, vecs[i].mw, vecs[i].f3, vecs[i].addr, vecs[i].sd, 1'b1, 5'd10);
            if (vecs[i].mis) misCycle($sformatf("vec%0d", i));
            else runMem(vecs[i].mw, vecs[i].strb, vecs[i].wd, vecs[i].ld, vecs[i].gd, vecs[i].rvd,
                        vecs[i].rdat, $sformatf("vec%0d", i));
        end

        // Randomized mix checked against the reference model
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 9);
            addr = $urandom;
            sd   = $urandom;
            rdat = $urandom;
            if (kind < 2) begin
                setInstr(1'(kind), kind == 0 ? 1'($urandom_range(0, 1)) : 1'b0,
                         kind == 0 ? 1'($urandom_range(0, 1)) : 1'b0, 3'($urandom_range(0, 7)),
                         addr, sd, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
                bus.mem_rvalid = 1'($urandom_range(0, 1));
                bus.mem_rdata  = rdat;
                passCycle($sformatf("rnd%0d pass", i));
                bus.mem_rvalid = 1'b0;
            end else begin
                mw = (kind >= 6);
                mr = mw ? 1'($urandom_range(0, 1)) : 1'b1;
                if (mw) f3 = 3'($urandom_range(0, 2));
                else begin
                    case ($urandom_range(0, 4))
                        0:       f3 = 3'b000;
                        1:       f3 = 3'b001;
                        2:       f3 = 3'b010;
                        3:       f3 = 3'b100;
                        default: f3 = 3'b101;
                    endcase
                end
                model(f3, addr, sd, rdat, mis, strb, wd, ld);
                setInstr(1'b1, mr, mw, f3, addr, sd, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
                if (mis) misCycle($sformatf("rnd%0d mis", i));
                else runMem(mw, strb, wd, ld, $urandom_range(0, 3), $urandom_range(0, 3), rdat,
                            $sformatf("rnd%0d mem", i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
